// File: rtl/arp_table_lookup.sv
// arp_table_lookup: next-hop IPv4 to MAC resolution by sequential search of a register-programmed ARP table.
//   AXI_ACLK, reset        : clock, synchronous active-high reset
//   lookup_req/ip/oq       : request strobe with next-hop key and one-hot output queue
//   lookup_busy/done       : busy from the cycle after accept through done; one-cycle done strobe
//   arp_hit/dest_mac/oq_reg: result, held until the next done
//   tbl_wr_*               : table entry write port
//   tbl_rd_*               : registered table readback
//   counter_clear, arp_lookup_count, arp_hit_count : statistics
module arp_table_lookup #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TABLE_DEPTH        = 32,
    parameter int TABLE_ADDR_WIDTH   = 5
) (
    input  logic                          AXI_ACLK,
    input  logic                          reset,
    input  logic                          lookup_req,
    input  logic [31:0]                   lookup_ip,
    input  logic [7:0]                    lookup_oq,
    output logic                          lookup_busy,
    output logic                          lookup_done,
    output logic                          arp_hit,
    output logic [47:0]                   dest_mac,
    output logic [31:0]                   oq_reg,
    input  logic                          tbl_wr_en,
    input  logic [TABLE_ADDR_WIDTH-1:0]   tbl_wr_addr,
    input  logic [31:0]                   tbl_wr_ip,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_mac_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_mac_high,
    input  logic                          tbl_wr_valid,
    input  logic [TABLE_ADDR_WIDTH-1:0]   tbl_rd_addr,
    output logic [31:0]                   tbl_rd_ip,
    output logic [47:0]                   tbl_rd_mac,
    output logic                          tbl_rd_valid,
    input  logic                          counter_clear,
    output logic [C_S_AXI_DATA_WIDTH-1:0] arp_lookup_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0] arp_hit_count
);
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;
    localparam logic [TABLE_ADDR_WIDTH-1:0] LAST_IDX = TABLE_ADDR_WIDTH'(TABLE_DEPTH - 1);
    state_t                          r_state, w_next;
    logic [31:0]                     r_ip [TABLE_DEPTH];
    logic [47:0]                     r_mac [TABLE_DEPTH];
    logic [TABLE_DEPTH-1:0]          r_valid;
    logic [TABLE_ADDR_WIDTH-1:0]     r_idx;
    logic [31:0]                     r_key;
    logic [7:0]                      r_oq;
    logic                            r_hit;
    logic [47:0]                     r_dest_mac;
    logic [31:0]                     r_oq_reg;
    logic [31:0]                     r_rd_ip;
    logic [47:0]                     r_rd_mac;
    logic                            r_rd_valid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_lookup_cnt, r_hit_cnt;
    logic                            w_accept, w_match, w_last, w_wr_ok, w_rd_ok;
    logic                            w_unused_mac_high;
    assign w_unused_mac_high = ^tbl_wr_mac_high[C_S_AXI_DATA_WIDTH-1:16];
    assign w_accept = (r_state == S_IDLE) && lookup_req;
    assign w_match  = r_valid[r_idx] && (r_ip[r_idx] == r_key);
    assign w_last   = (r_idx == LAST_IDX);
    assign w_wr_ok  = tbl_wr_en && (32'(tbl_wr_addr) < TABLE_DEPTH);
    assign w_rd_ok  = 32'(tbl_rd_addr) < TABLE_DEPTH;
    always_ff @(posedge AXI_ACLK) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = lookup_req ? S_SEARCH : S_IDLE;
            S_SEARCH: w_next = (w_match || w_last) ? S_DONE : S_SEARCH;
            default:  w_next = S_IDLE;
        endcase
    end
    // Results are written on the SEARCH->DONE edge so they are already visible in the done cycle.
    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            r_idx      <= '0;
            r_key      <= '0;
            r_oq       <= '0;
            r_hit      <= 1'b0;
            r_dest_mac <= '0;
            r_oq_reg   <= '0;
        end else begin
            if (w_accept) begin
                r_key <= lookup_ip;
                r_oq  <= lookup_oq;
                r_idx <= '0;
            end
            if (r_state == S_SEARCH) begin
                if (w_match) begin
                    r_hit      <= 1'b1;
                    r_dest_mac <= r_mac[r_idx];
                    r_oq_reg   <= {24'b0, r_oq};
                end else if (w_last) begin
                    r_hit      <= 1'b0;
                    r_dest_mac <= '0;
                    r_oq_reg   <= '0;
                end else begin
                    r_idx <= r_idx + TABLE_ADDR_WIDTH'(1);
                end
            end
        end
    end
    // Entry contents need no reset; only the valid bits gate matching.
    always_ff @(posedge AXI_ACLK) begin
        if (w_wr_ok) begin
            r_ip[tbl_wr_addr]  <= tbl_wr_ip;
            r_mac[tbl_wr_addr] <= {tbl_wr_mac_high[15:0], tbl_wr_mac_low[31:0]};
        end
    end
    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            r_valid    <= '0;
            r_rd_ip    <= '0;
            r_rd_mac   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_ok) r_valid[tbl_wr_addr] <= tbl_wr_valid;
            r_rd_ip    <= w_rd_ok ? r_ip[tbl_rd_addr] : 32'b0;
            r_rd_mac   <= w_rd_ok ? r_mac[tbl_rd_addr] : 48'b0;
            r_rd_valid <= w_rd_ok && r_valid[tbl_rd_addr];
        end
    end
    always_ff @(posedge AXI_ACLK) begin
        if (reset || counter_clear) begin
            r_lookup_cnt <= '0;
            r_hit_cnt    <= '0;
        end else begin
            if (w_accept) r_lookup_cnt <= r_lookup_cnt + C_S_AXI_DATA_WIDTH'(1);
            if (r_state == S_DONE && r_hit) r_hit_cnt <= r_hit_cnt + C_S_AXI_DATA_WIDTH'(1);
        end
    end
    assign lookup_busy      = (r_state != S_IDLE);
    assign lookup_done      = (r_state == S_DONE);
    assign arp_hit          = r_hit;
    assign dest_mac         = r_dest_mac;
    assign oq_reg           = r_oq_reg;
    assign tbl_rd_ip        = r_rd_ip;
    assign tbl_rd_mac       = r_rd_mac;
    assign tbl_rd_valid     = r_rd_valid;
    assign arp_lookup_count = r_lookup_cnt;
    assign arp_hit_count    = r_hit_cnt;
endmodule

// File: tb/tb_arp_table_lookup.sv
// tb_arp_table_lookup: scoreboard bench for arp_table_lookup.
module tb_arp_table_lookup;
    logic        AXI_ACLK = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_req = 1'b0;
    logic [31:0] lookup_ip = '0;
    logic [7:0]  lookup_oq = '0;
    logic        lookup_busy, lookup_done, arp_hit;
    logic [47:0] dest_mac;
    logic [31:0] oq_reg;
    logic        tbl_wr_en = 1'b0;
    logic [4:0]  tbl_wr_addr = '0;
    logic [31:0] tbl_wr_ip = '0;
    logic [31:0] tbl_wr_mac_low = '0;
    logic [31:0] tbl_wr_mac_high = '0;
    logic        tbl_wr_valid = 1'b0;
    logic [4:0]  tbl_rd_addr = '0;
    logic [31:0] tbl_rd_ip;
    logic [47:0] tbl_rd_mac;
    logic        tbl_rd_valid;
    logic        counter_clear = 1'b0;
    logic [31:0] arp_lookup_count, arp_hit_count;

    typedef struct {
        logic        hit;
        logic [47:0] mac;
        logic [31:0] oq;
        int          due;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] IP_X   = 32'h0A000002;
    localparam logic [31:0] IP_DUP = 32'h0A000063;
    localparam logic [31:0] IP_Z   = 32'hC0A80101;
    localparam logic [47:0] MAC_1  = 48'h001122334455;
    localparam logic [47:0] MAC_A  = 48'hAAAA00000005;
    localparam logic [47:0] MAC_B  = 48'hBBBB00000014;
    localparam logic [47:0] MAC_C  = 48'hCCCC0000000A;
    localparam logic [47:0] MAC_D  = 48'hDDDD0000000A;

    arp_table_lookup dut (
        .AXI_ACLK(AXI_ACLK), .reset(reset),
        .lookup_req(lookup_req), .lookup_ip(lookup_ip), .lookup_oq(lookup_oq),
        .lookup_busy(lookup_busy), .lookup_done(lookup_done),
        .arp_hit(arp_hit), .dest_mac(dest_mac), .oq_reg(oq_reg),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_ip(tbl_wr_ip),
        .tbl_wr_mac_low(tbl_wr_mac_low), .tbl_wr_mac_high(tbl_wr_mac_high),
        .tbl_wr_valid(tbl_wr_valid), .tbl_rd_addr(tbl_rd_addr),
        .tbl_rd_ip(tbl_rd_ip), .tbl_rd_mac(tbl_rd_mac), .tbl_rd_valid(tbl_rd_valid),
        .counter_clear(counter_clear),
        .arp_lookup_count(arp_lookup_count), .arp_hit_count(arp_hit_count)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;
    always @(posedge AXI_ACLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every done pops one expectation, including its cycle.
    always @(negedge AXI_ACLK) begin
        if (lookup_done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("arp_hit", {63'b0, arp_hit}, {63'b0, e.hit});
                chk("dest_mac", {16'b0, dest_mac}, {16'b0, e.mac});
                chk("oq_reg", {32'b0, oq_reg}, {32'b0, e.oq});
                chk("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge AXI_ACLK);
            n++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic tbl_write(input logic [4:0] a, input logic [31:0] ip, input logic [47:0] mac, input logic v);
        @(negedge AXI_ACLK);
        tbl_wr_en = 1'b1;
        tbl_wr_addr = a;
        tbl_wr_ip = ip;
        tbl_wr_mac_low = mac[31:0];
        tbl_wr_mac_high = {16'hFFFF, mac[47:32]};
        tbl_wr_valid = v;
        @(negedge AXI_ACLK);
        tbl_wr_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ip, input logic [7:0] oq, input logic hit, input logic [47:0] mac, input int lat);
        @(negedge AXI_ACLK);
        lookup_req = 1'b1;
        lookup_ip = ip;
        lookup_oq = oq;
        q.push_back('{hit, hit ? mac : 48'b0, hit ? {24'b0, oq} : 32'b0, cyc + lat});
    endtask

    task automatic do_lookup(input logic [31:0] ip, input logic [7:0] oq, input logic hit, input logic [47:0] mac, input int lat);
        issue(ip, oq, hit, mac, lat);
        @(negedge AXI_ACLK);
        lookup_req = 1'b0;
        wait_idle();
        @(negedge AXI_ACLK);
    endtask

    task automatic chk_counts(input string tag, input int lk, input int ht);
        chk({tag, "_lookup_count"}, {32'b0, arp_lookup_count}, 64'(lk));
        chk({tag, "_hit_count"}, {32'b0, arp_hit_count}, 64'(ht));
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge AXI_ACLK);
        chk("rst_busy", {63'b0, lookup_busy}, 64'd0);
        chk("rst_done", {63'b0, lookup_done}, 64'd0);
        chk("rst_hit", {63'b0, arp_hit}, 64'd0);
        chk("rst_mac", {16'b0, dest_mac}, 64'd0);
        chk("rst_oq", {32'b0, oq_reg}, 64'd0);
        chk("rst_rd_valid", {63'b0, tbl_rd_valid}, 64'd0);
        chk_counts("rst", 0, 0);
        reset = 1'b0;

        // Hit at index 3: done in cycle 5.
        tbl_write(5'd3, IP_X, MAC_1, 1'b1);
        do_lookup(IP_X, 8'h04, 1'b1, MAC_1, 5);
        chk_counts("t1", 1, 1);

        // Empty table miss: done in cycle 33.
        tbl_write(5'd3, IP_X, MAC_1, 1'b0);
        do_lookup(32'h0A000009, 8'h02, 1'b0, '0, 33);
        chk_counts("t2", 2, 1);

        // Duplicates: lowest index wins, then the higher one once it is invalidated.
        tbl_write(5'd5, IP_DUP, MAC_A, 1'b1);
        tbl_write(5'd20, IP_DUP, MAC_B, 1'b1);
        do_lookup(IP_DUP, 8'h10, 1'b1, MAC_A, 7);
        tbl_write(5'd5, IP_DUP, MAC_A, 1'b0);
        do_lookup(IP_DUP, 8'h10, 1'b1, MAC_B, 22);
        chk_counts("t3", 4, 3);

        // Request while busy is dropped; clear coincides with the hit done cycle.
        @(negedge AXI_ACLK);
        counter_clear = 1'b1;
        @(negedge AXI_ACLK);
        counter_clear = 1'b0;
        chk_counts("t4_pre", 0, 0);
        issue(IP_DUP, 8'h20, 1'b1, MAC_B, 22);
        c0 = cyc;
        @(negedge AXI_ACLK);
        chk("t4_busy", {63'b0, lookup_busy}, 64'd1);
        lookup_ip = 32'h0A000077;
        @(negedge AXI_ACLK);
        lookup_req = 1'b0;
        while (cyc < c0 + 10) @(negedge AXI_ACLK);
        chk_counts("t4_mid", 1, 0);
        while (cyc < c0 + 22) @(negedge AXI_ACLK);
        counter_clear = 1'b1;
        @(negedge AXI_ACLK);
        counter_clear = 1'b0;
        chk_counts("t4_post", 0, 0);
        repeat (40) @(negedge AXI_ACLK);
        wait_idle();

        // MAC rewritten in the cycle index 10 is compared: old MAC returned.
        tbl_write(5'd10, IP_Z, MAC_C, 1'b1);
        tbl_rd_addr = 5'd10;
        issue(IP_Z, 8'h01, 1'b1, MAC_C, 12);
        c0 = cyc;
        @(negedge AXI_ACLK);
        lookup_req = 1'b0;
        while (cyc < c0 + 11) @(negedge AXI_ACLK);
        tbl_wr_en = 1'b1;
        tbl_wr_addr = 5'd10;
        tbl_wr_ip = IP_Z;
        tbl_wr_mac_low = MAC_D[31:0];
        tbl_wr_mac_high = {16'h0, MAC_D[47:32]};
        tbl_wr_valid = 1'b1;
        @(negedge AXI_ACLK);
        tbl_wr_en = 1'b0;
        chk("t5_rd_same_cycle", {16'b0, tbl_rd_mac}, {16'b0, MAC_C});
        @(negedge AXI_ACLK);
        chk("t5_rd_mac", {16'b0, tbl_rd_mac}, {16'b0, MAC_D});
        chk("t5_rd_ip", {32'b0, tbl_rd_ip}, {32'b0, IP_Z});
        chk("t5_rd_valid", {63'b0, tbl_rd_valid}, 64'd1);
        wait_idle();

        // Reset in cycle 10 of a search: no done, state and stats cleared.
        issue(IP_DUP, 8'h08, 1'b0, '0, 0);
        void'(q.pop_back());
        c0 = cyc;
        @(negedge AXI_ACLK);
        lookup_req = 1'b0;
        while (cyc < c0 + 10) @(negedge AXI_ACLK);
        reset = 1'b1;
        @(negedge AXI_ACLK);
        reset = 1'b0;
        chk("t6_busy", {63'b0, lookup_busy}, 64'd0);
        chk("t6_done", {63'b0, lookup_done}, 64'd0);
        chk("t6_rd_valid", {63'b0, tbl_rd_valid}, 64'd0);
        chk_counts("t6", 0, 0);
        repeat (30) @(negedge AXI_ACLK);
        do_lookup(IP_DUP, 8'h08, 1'b0, '0, 33);
        chk_counts("t6_after", 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
